// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic matmul.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_N    = 4;
    localparam int DEF_DW   = 16;
    localparam int DEF_CNTW = $clog2(2 * DEF_N);

    // Full product width plus log2(N) growth, plus one bit so a single
    // accumulate pass cannot wrap.
    function automatic int accw(input int n, input int dw);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    // Beat and drain counters must reach 2N-2.
    function automatic int cntw(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: registered a/b pass-through plus a MAC accumulator.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW     = 16,
    parameter int ACCW   = 35,
    parameter int SIGNED = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   b_in,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    output logic [ACCW-1:0] acc
);

    logic [ACCW-1:0] prod_ext;

    // The multiply uses the registered operands, which are also what gets forwarded.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DW-1:0] prod_s;
            assign prod_s   = $signed(a_out) * $signed(b_out);
            assign prod_ext = {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
        end else begin : g_unsigned
            logic [2*DW-1:0] prod_u;
            assign prod_u   = a_out * b_out;
            assign prod_ext = {{(ACCW-2*DW){1'b0}}, prod_u};
        end
    endgenerate

    // Operand pass registers always shift; clear wins over accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clr)
                acc <= '0;
            else if (en)
                acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_matmul_nxn.sv
// NxN output-stationary systolic multiplier: A streamed by column, B by row,
// skewed internally, full C tile returned on a valid/ready handshake.
module systolic_matmul_nxn
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int SIGNED = 1,
    parameter int ACCW   = accw(N, DW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DW-1:0]       a_col,
    input  logic [N*DW-1:0]       b_row,
    input  logic                  accumulate,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*N*ACCW-1:0]   c_flat,
    output logic                  busy
);

    localparam int CNTW = cntw(N);

    state_t          state, state_nxt;
    logic [CNTW-1:0] beat_cnt, drain_cnt;
    logic            accept, last_beat, drain_end;
    logic            clr_acc, en_acc;

    logic [DW-1:0]   a_inj  [N];
    logic [DW-1:0]   b_inj  [N];
    logic [DW-1:0]   a_edge [N];
    logic [DW-1:0]   b_edge [N];

    assign accept    = in_valid && in_ready;
    assign last_beat = (state == LOAD) && accept && (beat_cnt == CNTW'(N - 1));
    assign drain_end = (state == DRAIN) && (drain_cnt == CNTW'(2 * N - 2));
    assign clr_acc   = (state == IDLE) && accept && !accumulate;
    assign en_acc    = (state == LOAD) || (state == DRAIN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = LOAD;
            LOAD:    if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            LOAD:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Beat counter tracks accepted beats; drain counter times the 2N-1 flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) beat_cnt <= CNTW'(1);
                LOAD: begin
                    if (accept)    beat_cnt  <= beat_cnt + CNTW'(1);
                    if (last_beat) drain_cnt <= '0;
                end
                DRAIN: begin
                    beat_cnt  <= '0;
                    drain_cnt <= drain_cnt + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    // Non-accepted cycles inject zeros so stalls add nothing to C.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = accept ? a_col[i*DW +: DW] : '0;
            b_inj[i] = accept ? b_row[i*DW +: DW] : '0;
        end
    end

    // Triangular skew: row i of A and column i of B are delayed i cycles.
    generate
        for (genvar i = 0; i < N; i++) begin : g_skew
            if (i == 0) begin : g_direct
                assign a_edge[i] = a_inj[i];
                assign b_edge[i] = b_inj[i];
            end else begin : g_delay
                logic [DW-1:0] a_sr [i];
                logic [DW-1:0] b_sr [i];
                // Zero-filled shift line of depth i.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int k = 0; k < i; k++) begin
                            a_sr[k] <= '0;
                            b_sr[k] <= '0;
                        end
                    end else begin
                        a_sr[0] <= a_inj[i];
                        b_sr[0] <= b_inj[i];
                        for (int k = 1; k < i; k++) begin
                            a_sr[k] <= a_sr[k-1];
                            b_sr[k] <= b_sr[k-1];
                        end
                    end
                end
                assign a_edge[i] = a_sr[i-1];
                assign b_edge[i] = b_sr[i-1];
            end
        end
    endgenerate

    // PE mesh: a flows right along rows, b flows down along columns.
    logic [DW-1:0] a_h [N][N];
    logic [DW-1:0] b_v [N][N];
    logic [DW-1:0] a_unused [N];
    logic [DW-1:0] b_unused [N];

    generate
        for (genvar i = 0; i < N; i++) begin : g_row
            for (genvar j = 0; j < N; j++) begin : g_col
                logic [DW-1:0] pa, pb;

                if (j == 0) begin : g_ain
                    assign a_h[i][j] = a_edge[i];
                end
                if (i == 0) begin : g_bin
                    assign b_v[i][j] = b_edge[j];
                end

                if (j < N - 1) begin : g_aout
                    assign a_h[i][j+1] = pa;
                end else begin : g_asink
                    assign a_unused[i] = pa;
                end
                if (i < N - 1) begin : g_bout
                    assign b_v[i+1][j] = pb;
                end else begin : g_bsink
                    assign b_unused[j] = pb;
                end

                systolic_pe #(
                    .DW     (DW),
                    .ACCW   (ACCW),
                    .SIGNED (SIGNED)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .clr   (clr_acc),
                    .en    (en_acc),
                    .a_in  (a_h[i][j]),
                    .b_in  (b_v[i][j]),
                    .a_out (pa),
                    .b_out (pb),
                    .acc   (c_flat[(i*N+j)*ACCW +: ACCW])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed bench: 2x2 signed instance plus signed/unsigned 4x4 instances
// sharing one stimulus stream, checked against a queued reference model.
module tb_systolic_matmul_nxn;

    localparam int DW  = 16;
    localparam int A2W = 34;
    localparam int A4W = 35;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               v2, r2, acc2, ov2, ordy2, busy2;
    logic [2*DW-1:0]    a2, b2;
    logic [4*A2W-1:0]   c2;

    logic               v4, acc4, ordy4;
    logic [4*DW-1:0]    a4, b4;
    logic               r4s, r4u, ov4s, ov4u, busy4s, busy4u;
    logic [16*A4W-1:0]  c4s, c4u;

    int errors = 0;
    int checks = 0;

    logic [1023:0] q2[$];
    logic [1023:0] q4s[$];
    logic [1023:0] q4u[$];

    logic [DW-1:0] MA [4][4];
    logic [DW-1:0] MB [4][4];

    systolic_matmul_nxn #(.N(2), .DW(DW), .SIGNED(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .a_col(a2), .b_row(b2),
        .accumulate(acc2), .out_valid(ov2), .out_ready(ordy2), .c_flat(c2), .busy(busy2));

    systolic_matmul_nxn #(.N(4), .DW(DW), .SIGNED(1)) dut4s (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4s), .a_col(a4), .b_row(b4),
        .accumulate(acc4), .out_valid(ov4s), .out_ready(ordy4), .c_flat(c4s), .busy(busy4s));

    systolic_matmul_nxn #(.N(4), .DW(DW), .SIGNED(0)) dut4u (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4u), .a_col(a4), .b_row(b4),
        .accumulate(acc4), .out_valid(ov4u), .out_ready(ordy4), .c_flat(c4u), .busy(busy4u));

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference C = A*B for the n x n corner of MA/MB, packed at slice i*n+j, width w.
    function automatic logic [1023:0] mm(input int n, input int w, input bit sgn);
        logic [1023:0] r;
        logic [63:0]   s, mask;
        longint        x, y;
        r    = '0;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = '0;
                for (int k = 0; k < n; k++) begin
                    x = sgn ? longint'($signed(MA[i][k])) : longint'({48'd0, MA[i][k]});
                    y = sgn ? longint'($signed(MB[k][j])) : longint'({48'd0, MB[k][j]});
                    s = s + 64'(x * y);
                end
                r = r | (1024'(s & mask) << ((i*n+j)*w));
            end
        return r;
    endfunction

    task automatic feed2(input bit acc);
        for (int k = 0; k < 2; k++) begin
            v2 = 1'b1;
            for (int i = 0; i < 2; i++) a2[i*DW +: DW] = MA[i][k];
            for (int j = 0; j < 2; j++) b2[j*DW +: DW] = MB[k][j];
            acc2 = (k == 0) ? acc : 1'b0;
            @(negedge clk);
        end
        v2 = 1'b0;
        a2 = '0;
        b2 = '0;
    endtask

    task automatic feed4(input bit gaps);
        logic [1023:0] e;
        e = mm(4, A4W, 1'b1); q4s.push_back(e);
        e = mm(4, A4W, 1'b0); q4u.push_back(e);
        for (int k = 0; k < 4; k++) begin
            v4 = 1'b1;
            for (int i = 0; i < 4; i++) a4[i*DW +: DW] = MA[i][k];
            for (int j = 0; j < 4; j++) b4[j*DW +: DW] = MB[k][j];
            acc4 = 1'b0;
            @(negedge clk);
            if (gaps && k < 3) begin
                v4 = 1'b0;
                a4 = {$urandom, $urandom};
                b4 = {$urandom, $urandom};
                @(negedge clk);
            end
        end
        v4 = 1'b0;
        a4 = '0;
        b4 = '0;
    endtask

    task automatic collect2(input string tag, input int lat);
        int n = 0;
        bit rdy_bad = 1'b0;
        logic [1023:0] e;
        while (!ov2 && n < 200) begin
            if (r2 !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, ov2, 1);
        if (lat >= 0) chk({tag, "_lat"}, n, lat);
        if (r2 !== 1'b0) rdy_bad = 1'b1;
        chk({tag, "_inrdy"}, rdy_bad, 0);
        e = (q2.size() > 0) ? q2.pop_front() : '1;
        chk({tag, "_c"}, c2, e);
        @(negedge clk);
        chk({tag, "_busy_after"}, {ov2, busy2}, 2'b00);
    endtask

    task automatic collect4(input string tag, input int lat);
        int n = 0;
        bit rdy_bad = 1'b0;
        logic [1023:0] e;
        while (!ov4s && n < 200) begin
            if (r4s !== 1'b0 || r4u !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {ov4s, ov4u}, 2'b11);
        if (lat >= 0) chk({tag, "_lat"}, n, lat);
        if (r4s !== 1'b0 || r4u !== 1'b0) rdy_bad = 1'b1;
        chk({tag, "_inrdy"}, rdy_bad, 0);
        e = (q4s.size() > 0) ? q4s.pop_front() : '1;
        chk({tag, "_c_s"}, c4s, e);
        e = (q4u.size() > 0) ? q4u.pop_front() : '1;
        chk({tag, "_c_u"}, c4u, e);
        if (ordy4) begin
            @(negedge clk);
            chk({tag, "_busy_after"}, {ov4s, busy4s, ov4u, busy4u}, 4'b0000);
        end
    endtask

    initial begin
        bit hold_bad;
        logic [1023:0] snap;

        rst = 1'b1;
        v2 = 0; a2 = '0; b2 = '0; acc2 = 0; ordy2 = 1;
        v4 = 0; a4 = '0; b4 = '0; acc4 = 0; ordy4 = 1;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_n2", {r2, ov2, busy2}, 3'b100);
        chk("rst_c2", c2, 0);
        chk("rst_n4", {r4s, ov4s, busy4s, r4u, ov4u, busy4u}, 6'b100100);
        chk("rst_c4", c4s | c4u, 0);
        rst = 1'b0;
        @(negedge clk);

        // 2x2 basic tile; last beat is followed by 2N-1 more negedges to out_valid
        MA[0][0] = 1; MA[0][1] = 2; MA[1][0] = 3; MA[1][1] = 4;
        MB[0][0] = 5; MB[0][1] = 6; MB[1][0] = 7; MB[1][1] = 8;
        q2.push_back(1024'({34'd50, 34'd43, 34'd22, 34'd19}));
        feed2(1'b0);
        collect2("t1", 3);

        // accumulate tile starts the cycle right after the handshake
        q2.push_back(1024'({34'd100, 34'd86, 34'd44, 34'd38}));
        feed2(1'b1);
        collect2("t4_acc", 3);
        q2.push_back(1024'({34'd50, 34'd43, 34'd22, 34'd19}));
        feed2(1'b0);
        collect2("t4_clr", 3);

        // 4x4 identity * (1..16) with input gaps
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                MA[i][j] = (i == j) ? 16'd1 : 16'd0;
                MB[i][j] = 16'(i*4 + j + 1);
            end
        feed4(1'b1);
        collect4("t2_ident", -1);

        // extreme operands back-to-back
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                MA[i][j] = 16'h8000;
                MB[i][j] = 16'h8000;
            end
        feed4(1'b0);
        collect4("t3_min", 7);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                MA[i][j] = 16'hFFFF;
                MB[i][j] = 16'hFFFF;
            end
        feed4(1'b0);
        collect4("t3_ffff", 7);

        // back-pressure: hold out_ready low 20 cycles, with stray in_valid
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                MA[i][j] = 16'($urandom);
                MB[i][j] = 16'($urandom);
            end
        ordy4 = 1'b0;
        feed4(1'b0);
        collect4("t5_first", 7);
        snap = 1024'({c4s, c4u});
        hold_bad = 1'b0;
        v4 = 1'b1;
        a4 = {$urandom, $urandom};
        b4 = {$urandom, $urandom};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!(ov4s === 1'b1 && ov4u === 1'b1 && r4s === 1'b0)) hold_bad = 1'b1;
            if (1024'({c4s, c4u}) !== snap) hold_bad = 1'b1;
        end
        chk("t5_hold", hold_bad, 0);
        ordy4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        chk("t5_release", {ov4s, busy4s, r4s}, 3'b001);
        @(negedge clk);
        chk("t5_idle", {ov4s, busy4s}, 2'b00);

        // reset during DRAIN discards the tile
        feed4(1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_drain", {busy4s, r4s}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst", {ov4s, busy4s, r4s}, 3'b001);
        chk("t6_rst_c", c4s | c4u, 0);
        q4s.delete();
        q4u.delete();

        // fresh random tile after reset
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                MA[i][j] = 16'($urandom);
                MB[i][j] = 16'($urandom);
            end
        feed4(1'b0);
        collect4("t6_fresh", 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
